// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared types and constants for the instruction fetch front end
package rv_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - handshaked sequential instruction fetch with branch/jump redirect
module instr_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            fetch_misaligned
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic [XLEN-1:0] r_instr_pc_plus4;
    logic            r_discard;
    logic            r_misaligned;

    logic            w_pc_aligned;
    logic            w_target_aligned;
    logic            w_req_fire;
    logic [XLEN-1:0] w_pc_plus4;

    assign w_pc_aligned     = (r_pc[1:0] == 2'b00);
    assign w_target_aligned = (redirect_target[1:0] == 2'b00);
    assign w_req_fire       = (r_state == S_REQ) && w_pc_aligned && imem_req_ready;
    assign w_pc_plus4       = r_pc + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_pc             <= RESET_PC;
            r_instr          <= XLEN'(NOP_INSTR);
            r_instr_pc       <= RESET_PC;
            r_instr_pc_plus4 <= RESET_PC + XLEN'(4);
            r_discard        <= 1'b0;
            r_misaligned     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;

                S_REQ: begin
                    if (redirect_valid) begin
                        // A request accepted this cycle still carries the old pc; its data must be dropped.
                        r_pc <= redirect_target;
                        if (w_req_fire) begin
                            r_discard <= 1'b1;
                            r_state   <= S_WAIT;
                        end
                    end else if (!w_pc_aligned) begin
                        r_misaligned <= 1'b1;
                        r_state      <= S_FAULT;
                    end else if (imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_target;
                        if (imem_rsp_valid) begin
                            r_discard <= 1'b0;
                            r_state   <= S_REQ;
                        end else begin
                            r_discard <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= S_REQ;
                        end else begin
                            r_instr          <= imem_rdata;
                            r_instr_pc       <= r_pc;
                            r_instr_pc_plus4 <= w_pc_plus4;
                            r_pc             <= w_pc_plus4;
                            r_state          <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    if (redirect_valid) begin
                        r_pc    <= redirect_target;
                        r_state <= S_REQ;
                    end else if (instr_ready) begin
                        r_state <= S_REQ;
                    end
                end

                S_FAULT: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_target;
                        if (w_target_aligned) begin
                            r_misaligned <= 1'b0;
                            r_state      <= S_REQ;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A misaligned pc in S_REQ never presents a request; it falls into S_FAULT next edge.
    assign imem_req_valid   = (r_state == S_REQ) && w_pc_aligned;
    assign imem_addr        = r_pc;
    assign instr_valid      = (r_state == S_HOLD);
    assign instr            = r_instr;
    assign instr_pc         = r_instr_pc;
    assign instr_pc_plus4   = r_instr_pc_plus4;
    assign fetch_misaligned = r_misaligned;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction fetch stage for the RISC-V single-cycle core, converted to a handshaked front end. It owns the program counter, issues word reads to instruction memory over a valid/ready request channel, and presents fetched instructions plus their PC to the decode/controller stage. It consumes the controller's branch/jump decision (PCSrc) and target (PCTarget) as a redirect, discarding any stale in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- XLEN, 32: address and instruction width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  read data valid, one pulse per accepted request, latency >= 1 cycle.
- imem_rdata  in  XLEN  instruction word.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode consumes instruction.
- instr  out  XLEN  held instruction.
- instr_pc  out  XLEN  address of held instruction.
- instr_pc_plus4  out  XLEN  instr_pc + 4, for JAL/JALR link.
- redirect_valid  in  1  PCSrc from controller: take branch/jump.
- redirect_target  in  XLEN  PCTarget.
- fetch_misaligned  out  1  sticky fault: fetch address [1:0] != 0.

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT. Reset state S_IDLE; leaves unconditionally on the first clock edge after rst_n deasserts to S_REQ.
- S_REQ: if pc[1:0] != 0, set fetch_misaligned and go to S_FAULT with no request. Otherwise drive imem_req_valid=1, imem_addr=pc. On imem_req_ready, go to S_WAIT.
- S_WAIT: on imem_rsp_valid, if discard=0, capture instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, go to S_HOLD. If discard=1, drop data, clear discard, go to S_REQ.
- S_HOLD: instr_valid=1. On instr_ready, go to S_REQ. instr, instr_pc, and instr_pc_plus4 are stable while instr_valid=1 and instr_ready=0.
- S_FAULT: no requests. fetch_misaligned stays 1. An aligned redirect clears the flag, loads pc, and goes to S_REQ. A misaligned redirect stays in S_FAULT.
- Redirect has priority over the normal transition. pc<=redirect_target in all non-IDLE states.
  - S_REQ with imem_req_ready in the same cycle: the request with the old pc is accepted. Set discard=1 and go to S_WAIT.
  - S_WAIT without imem_rsp_valid: set discard=1 and stay. With imem_rsp_valid: drop data and go to S_REQ.
  - S_HOLD: the held instruction is invalidated and the FSM goes to S_REQ. If instr_ready is high in the same cycle, that handshake still counts as consumed.
- pc arithmetic is modulo 2^XLEN. 32'hFFFF_FFFC + 4 wraps to 0 without a fault.
- Responses arriving outside S_WAIT are protocol errors and are ignored.

## Timing
- Reset values:
  - Outputs: imem_req_valid=0, imem_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_pc_plus4=RESET_PC+4, fetch_misaligned=0.
  - Internal: discard=0.
- All outputs are registered or decoded from state/registers only. There is no combinational path from inputs to outputs.
- Best-case throughput is one instruction per 3 cycles with 1-cycle memory latency and instr_ready held high: REQ, WAIT, HOLD.
- Redirect to first request at the target: 1 cycle from S_HOLD/S_REQ. From S_WAIT it takes response latency + 1.
- Reset asserted mid-operation returns to S_IDLE immediately. The outstanding response is ignored, because S_IDLE does not sample imem_rsp_valid.

## Structure
- Shared package rv_fetch_pkg holds:
  - the fetch_state_t enum (5 states, 3-bit encoding);
  - NOP_INSTR = 32'h0000_0013;
  - the RESET_PC default.
- Single flat module. No sub-module is natural: the PC register, FSM, and holding register are tightly coupled through the redirect priority rules.

## Test plan
- Reset release, memory ready=1, latency 1, instr_ready=1:
  - addresses 0x0, 0x4, 0x8 requested every 3 cycles;
  - instr_pc/instr match the returned words;
  - instr_pc_plus4 = instr_pc + 4.
- Backpressure: hold instr_ready=0 for 5 cycles in S_HOLD -> instr/instr_pc stable, no new request; after release, next request is at 0x4.
- Redirect to 0x100 during S_WAIT with latency 4 -> returned word is discarded and instr_valid stays 0; next imem_addr=0x100; delivered instr_pc=0x100.
- Redirect to 0x200 in the same cycle as the S_REQ handshake at 0x8 -> response for 0x8 is dropped; next request is 0x200.
- Redirect to 0x102 -> fetch_misaligned=1, no requests for 10 cycles; a later redirect to 0x104 clears the flag and fetches 0x104.
- Wrap-around and async reset: with pc=0xFFFF_FFFC, the fetch is followed by a request at 0x0. Asserting rst_n=0 mid-WAIT gives immediate reset values, and the first request after release is at RESET_PC.
